// File: rtl/demux_conductual_1x2_fifo.sv
// -----------------------------------------------------------------------------
// demux_conductual_1x2_fifo
//
// Purpose:
//   Receive-side 1:2 demultiplexer for a valid-qualified word stream. Each
//   incoming word is steered by `selector` into one of two lane FIFOs
//   (DEPTH entries each). Every lane's consumer drains its FIFO with a pop
//   strobe; the popped word appears on the registered lane output one cycle
//   later, with a single-cycle valid pulse.
//
// Parameters:
//   DATA_W  width of data_in and of each data_out
//   DEPTH   entries per lane FIFO (power of two, >= 2)
//   CNT_W   width of each drop counter (only with DEMUX_DROP_CNT_EN)
//
// Ports:
//   clok           in   rising-edge clock
//   reset_L        in   asynchronous active-low reset
//   valid_in       in   data_in carries a word this cycle
//   selector       in   0 -> lane 0, 1 -> lane 1 (sampled with valid_in)
//   data_in        in   input word
//   pop0 / pop1    in   per-lane consumer read request
//   data_out0/1    out  registered lane word
//   valid_out0/1   out  one-cycle pulse per accepted pop
//   full0/1        out  lane FIFO holds DEPTH words
//   empty0/1       out  lane FIFO holds no words
//   drop_cnt0/1    out  saturating dropped-word counters (DEMUX_DROP_CNT_EN)
//   overflow       out  sticky: some word was dropped on a full lane
//
// Configuration:
//   Define DEMUX_DROP_CNT_EN to add the per-lane drop counters and their
//   ports. Without it, only the sticky overflow flag reports drops.
//
// Notes:
//   A pop is judged against the count held before this cycle's push, so a
//   push into an empty lane cannot be popped in the same cycle (no bypass).
//   A full lane still accepts a push when the same cycle pops a word out.
// -----------------------------------------------------------------------------
module demux_conductual_1x2_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
`ifdef DEMUX_DROP_CNT_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic              clok,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic              selector,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    output logic              full0,
    output logic              full1,
    output logic              empty0,
    output logic              empty1,
`ifdef DEMUX_DROP_CNT_EN
    output logic [CNT_W-1:0]  drop_cnt0,
    output logic [CNT_W-1:0]  drop_cnt1,
`endif
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    // Per-lane control, index 0 = lane 0, index 1 = lane 1
    logic [1:0]        sel_s;
    logic [1:0]        pop_s;
    logic [1:0]        pop_acc_s;
    logic [1:0]        push_s;
    logic [1:0]        drop_s;
    logic [PTR_W:0]    count_nxt_s [2];

    // Per-lane state
    logic [PTR_W-1:0]  wr_ptr_r    [2];
    logic [PTR_W-1:0]  rd_ptr_r    [2];
    logic [PTR_W:0]    count_r     [2];
    logic [DATA_W-1:0] mem_r       [2][DEPTH];
    logic [DATA_W-1:0] data_out_r  [2];
    logic [1:0]        valid_out_r;
    logic              overflow_r;

    // Decode lane selection, accepted pops, pushes and drops
    always_comb begin
        sel_s     = {selector, ~selector};
        pop_s     = {pop1, pop0};
        pop_acc_s = 2'b00;
        push_s    = 2'b00;
        drop_s    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            // Pop only sees the count from before this cycle's push
            pop_acc_s[k] = pop_s[k] & (count_r[k] != CNT_ZERO);
            // A full lane frees one slot when it is popped this same cycle
            push_s[k]    = valid_in & sel_s[k] &
                           ((count_r[k] != FULL_CNT) | pop_acc_s[k]);
            drop_s[k]    = valid_in & sel_s[k] &
                           (count_r[k] == FULL_CNT) & ~pop_acc_s[k];
        end
    end

    // Next occupancy count per lane: push +1, pop -1, both or neither hold
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            count_nxt_s[k] = count_r[k];
            case ({push_s[k], pop_acc_s[k]})
                2'b10:   count_nxt_s[k] = count_r[k] + CNT_ONE;
                2'b01:   count_nxt_s[k] = count_r[k] - CNT_ONE;
                default: count_nxt_s[k] = count_r[k];
            endcase
        end
    end

    // Lane pointers, counts and registered outputs
    always_ff @(posedge clok or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_r[k]   <= PTR_ZERO;
                rd_ptr_r[k]   <= PTR_ZERO;
                count_r[k]    <= CNT_ZERO;
                data_out_r[k] <= {DATA_W{1'b0}};
            end
            valid_out_r <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                count_r[k] <= count_nxt_s[k];
                if (push_s[k]) begin
                    wr_ptr_r[k] <= wr_ptr_r[k] + PTR_ONE;
                end else begin
                    wr_ptr_r[k] <= wr_ptr_r[k];
                end
                // data_out holds its last word whenever no pop is accepted
                if (pop_acc_s[k]) begin
                    rd_ptr_r[k]   <= rd_ptr_r[k] + PTR_ONE;
                    data_out_r[k] <= mem_r[k][rd_ptr_r[k]];
                end else begin
                    rd_ptr_r[k]   <= rd_ptr_r[k];
                    data_out_r[k] <= data_out_r[k];
                end
            end
            valid_out_r <= pop_acc_s;
        end
    end

    // FIFO storage; contents after reset are don't-care, so no reset here
    always_ff @(posedge clok) begin
        for (int k = 0; k < 2; k++) begin
            if (push_s[k]) begin
                mem_r[k][wr_ptr_r[k]] <= data_in;
            end else begin
                mem_r[k][wr_ptr_r[k]] <= mem_r[k][wr_ptr_r[k]];
            end
        end
    end

    // Sticky overflow flag, set by any dropped word on either lane
    always_ff @(posedge clok or negedge reset_L) begin
        if (!reset_L) begin
            overflow_r <= 1'b0;
        end else if (|drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] drop_cnt_r [2];

    // Saturating per-lane dropped-word counters
    always_ff @(posedge clok or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < 2; k++) begin
                drop_cnt_r[k] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (drop_s[k] && (drop_cnt_r[k] != DROP_MAX)) begin
                    drop_cnt_r[k] <= drop_cnt_r[k] + DROP_ONE;
                end else begin
                    drop_cnt_r[k] <= drop_cnt_r[k];
                end
            end
        end
    end

    assign drop_cnt0 = drop_cnt_r[0];
    assign drop_cnt1 = drop_cnt_r[1];
`endif

    assign data_out0  = data_out_r[0];
    assign data_out1  = data_out_r[1];
    assign valid_out0 = valid_out_r[0];
    assign valid_out1 = valid_out_r[1];
    assign overflow   = overflow_r;

    // Status flags decode directly from the occupancy counts
    assign full0  = (count_r[0] == FULL_CNT);
    assign full1  = (count_r[1] == FULL_CNT);
    assign empty0 = (count_r[0] == CNT_ZERO);
    assign empty1 = (count_r[1] == CNT_ZERO);

endmodule

// File: tb/tb_demux_conductual_1x2_fifo.sv
// -----------------------------------------------------------------------------
// tb_demux_conductual_1x2_fifo
//
// Directed self-checking bench for demux_conductual_1x2_fifo (DEPTH = 4,
// DATA_W = 2). Inputs change 1 time unit after each rising edge and outputs
// are sampled at that same point, away from the edge. With
// DEMUX_DROP_CNT_EN defined, the drop counters are also checked using
// CNT_W = 2 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_demux_conductual_1x2_fifo;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;
`ifdef DEMUX_DROP_CNT_EN
    localparam int CNT_W  = 2;
`endif

    logic              clok;
    logic              reset_L;
    logic              valid_in;
    logic              selector;
    logic [DATA_W-1:0] data_in;
    logic              pop0;
    logic              pop1;
    logic [DATA_W-1:0] data_out0;
    logic              valid_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out1;
    logic              full0;
    logic              full1;
    logic              empty0;
    logic              empty1;
    logic              overflow;
`ifdef DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0]  drop_cnt0;
    logic [CNT_W-1:0]  drop_cnt1;
`endif

    int checks;
    int errors;

`ifdef DEMUX_DROP_CNT_EN
    demux_conductual_1x2_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clok       (clok),
        .reset_L    (reset_L),
        .valid_in   (valid_in),
        .selector   (selector),
        .data_in    (data_in),
        .pop0       (pop0),
        .pop1       (pop1),
        .data_out0  (data_out0),
        .valid_out0 (valid_out0),
        .data_out1  (data_out1),
        .valid_out1 (valid_out1),
        .full0      (full0),
        .full1      (full1),
        .empty0     (empty0),
        .empty1     (empty1),
        .drop_cnt0  (drop_cnt0),
        .drop_cnt1  (drop_cnt1),
        .overflow   (overflow)
    );
`else
    demux_conductual_1x2_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clok       (clok),
        .reset_L    (reset_L),
        .valid_in   (valid_in),
        .selector   (selector),
        .data_in    (data_in),
        .pop0       (pop0),
        .pop1       (pop1),
        .data_out0  (data_out0),
        .valid_out0 (valid_out0),
        .data_out1  (data_out1),
        .valid_out1 (valid_out1),
        .full0      (full0),
        .full1      (full1),
        .empty0     (empty0),
        .empty1     (empty1),
        .overflow   (overflow)
    );
`endif

    // Free-running 10-unit clock
    initial clok = 1'b0;
    always #5 clok = ~clok;

    task automatic tick();
        @(posedge clok);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0;
        selector = 1'b0;
        data_in  = 2'b00;
        pop0     = 1'b0;
        pop1     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
        tick();
    endtask

    task automatic push(input logic sel, input logic [DATA_W-1:0] d);
        valid_in = 1'b1;
        selector = sel;
        data_in  = d;
        tick();
        valid_in = 1'b0;
    endtask

    // Power-on reset, then a mid-cycle asynchronous reset with traffic in flight
    task automatic test_reset();
        idle_inputs();
        reset_L = 1'b0;
        tick();
        tick();
        checks++; if (empty0 !== 1'b1 || empty1 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b%b want 11", empty0, empty1); end
        checks++; if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_valid: got v0=%b v1=%b ovf=%b want 0 0 0", valid_out0, valid_out1, overflow); end
        reset_L = 1'b1;
        tick();

        valid_in = 1'b1; selector = 1'b0; data_in = 2'b11;
        tick();
        selector = 1'b1; data_in = 2'b10; pop0 = 1'b1;
        tick();
        idle_inputs();
        checks++; if (data_out0 !== 2'b11 || valid_out0 !== 1'b1) begin errors++; $display("FAIL pre_reset_out0: got %b/%b want 11/1", data_out0, valid_out0); end
        checks++; if (empty1 !== 1'b0) begin errors++; $display("FAIL pre_reset_empty1: got %b want 0", empty1); end

        // Assert reset between edges; outputs must clear without a clock edge
        #3;
        reset_L = 1'b0;
        #1;
        checks++; if (data_out0 !== 2'b00 || valid_out0 !== 1'b0) begin errors++; $display("FAIL async_reset_out0: got %b/%b want 00/0", data_out0, valid_out0); end
        checks++; if (data_out1 !== 2'b00 || valid_out1 !== 1'b0) begin errors++; $display("FAIL async_reset_out1: got %b/%b want 00/0", data_out1, valid_out1); end
        checks++; if (empty0 !== 1'b1 || empty1 !== 1'b1 || full0 !== 1'b0 || full1 !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got e=%b%b f=%b%b want e=11 f=00", empty0, empty1, full0, full1); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL async_reset_ovf: got %b want 0", overflow); end
        tick();
        reset_L = 1'b1;
        tick();
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL post_reset_empty1: got %b want 1", empty1); end
    endtask

    // One word to each lane, popped one lane at a time
    task automatic test_routing();
        push(1'b0, 2'b01);
        push(1'b1, 2'b10);
        checks++; if (empty0 !== 1'b0 || empty1 !== 1'b0) begin errors++; $display("FAIL route_fill: got e=%b%b want 00", empty0, empty1); end
        pop0 = 1'b1;
        tick();
        pop0 = 1'b0;
        checks++; if (data_out0 !== 2'b01 || valid_out0 !== 1'b1) begin errors++; $display("FAIL route_lane0: got %b/%b want 01/1", data_out0, valid_out0); end
        checks++; if (valid_out1 !== 1'b0) begin errors++; $display("FAIL route_lane1_quiet: got %b want 0", valid_out1); end
        pop1 = 1'b1;
        tick();
        pop1 = 1'b0;
        checks++; if (data_out1 !== 2'b10 || valid_out1 !== 1'b1) begin errors++; $display("FAIL route_lane1: got %b/%b want 10/1", data_out1, valid_out1); end
        checks++; if (valid_out0 !== 1'b0 || data_out0 !== 2'b01) begin errors++; $display("FAIL route_lane0_hold: got %b/%b want 01/0", data_out0, valid_out0); end
        tick();
        checks++; if (valid_out1 !== 1'b0 || data_out1 !== 2'b10) begin errors++; $display("FAIL route_lane1_hold: got %b/%b want 10/0", data_out1, valid_out1); end
        checks++; if (empty0 !== 1'b1 || empty1 !== 1'b1) begin errors++; $display("FAIL route_drain: got e=%b%b want 11", empty0, empty1); end
    endtask

    // Six pushes into lane 0 with no pops: four stored, two dropped
    task automatic test_full_wrap();
        logic [DATA_W-1:0] exp_d;
        push(1'b0, 2'b00);
        push(1'b0, 2'b01);
        push(1'b0, 2'b10);
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL wrap_not_full3: got %b want 0", full0); end
        push(1'b0, 2'b11);
        checks++; if (full0 !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL wrap_full4: got full=%b ovf=%b want 1 0", full0, overflow); end
        push(1'b0, 2'b00);
        push(1'b0, 2'b01);
        checks++; if (overflow !== 1'b1 || full0 !== 1'b1) begin errors++; $display("FAIL wrap_overflow: got ovf=%b full=%b want 1 1", overflow, full0); end
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL wrap_lane1_untouched: got %b want 1", empty1); end
`ifdef DEMUX_DROP_CNT_EN
        checks++; if (drop_cnt0 !== 2'd2 || drop_cnt1 !== 2'd0) begin errors++; $display("FAIL wrap_drop_cnt: got %0d/%0d want 2/0", drop_cnt0, drop_cnt1); end
`endif
        pop0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_d = 2'(i);
            checks++; if (data_out0 !== exp_d || valid_out0 !== 1'b1) begin errors++; $display("FAIL wrap_pop%0d: got %b/%b want %b/1", i, data_out0, valid_out0, exp_d); end
        end
        pop0 = 1'b0;
        tick();
        checks++; if (empty0 !== 1'b1 || valid_out0 !== 1'b0) begin errors++; $display("FAIL wrap_empty: got e=%b v=%b want 1 0", empty0, valid_out0); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_ovf_sticky: got %b want 1", overflow); end
    endtask

    // Full lane 1 pushed and popped in the same cycle: no drop
    task automatic test_full_push_pop();
        logic [DATA_W-1:0] exp_q [4];
        do_reset();
        push(1'b1, 2'b00);
        push(1'b1, 2'b01);
        push(1'b1, 2'b10);
        push(1'b1, 2'b00);
        checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b want 1", full1); end
        valid_in = 1'b1; selector = 1'b1; data_in = 2'b11; pop1 = 1'b1;
        tick();
        valid_in = 1'b0;
        checks++; if (data_out1 !== 2'b00 || valid_out1 !== 1'b1) begin errors++; $display("FAIL fpp_first: got %b/%b want 00/1", data_out1, valid_out1); end
        checks++; if (full1 !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_drop: got full=%b ovf=%b want 1 0", full1, overflow); end
`ifdef DEMUX_DROP_CNT_EN
        checks++; if (drop_cnt1 !== 2'd0) begin errors++; $display("FAIL fpp_drop_cnt: got %0d want 0", drop_cnt1); end
`endif
        exp_q[0] = 2'b01; exp_q[1] = 2'b10; exp_q[2] = 2'b00; exp_q[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (data_out1 !== exp_q[i] || valid_out1 !== 1'b1) begin errors++; $display("FAIL fpp_pop%0d: got %b/%b want %b/1", i, data_out1, valid_out1, exp_q[i]); end
        end
        pop1 = 1'b0;
        tick();
        checks++; if (empty1 !== 1'b1 || valid_out1 !== 1'b0) begin errors++; $display("FAIL fpp_empty: got e=%b v=%b want 1 0", empty1, valid_out1); end
    endtask

    // Pop on an empty lane, and push+pop on an empty lane
    task automatic test_empty_edges();
        push(1'b0, 2'b10);
        pop0 = 1'b1;
        tick();
        checks++; if (data_out0 !== 2'b10 || valid_out0 !== 1'b1) begin errors++; $display("FAIL edge_setup: got %b/%b want 10/1", data_out0, valid_out0); end
        tick();
        checks++; if (valid_out0 !== 1'b0 || data_out0 !== 2'b10) begin errors++; $display("FAIL edge_pop_empty: got %b/%b want 10/0", data_out0, valid_out0); end
        valid_in = 1'b1; selector = 1'b0; data_in = 2'b01;
        tick();
        valid_in = 1'b0;
        checks++; if (valid_out0 !== 1'b0 || data_out0 !== 2'b10) begin errors++; $display("FAIL edge_no_bypass: got %b/%b want 10/0", data_out0, valid_out0); end
        checks++; if (empty0 !== 1'b0) begin errors++; $display("FAIL edge_count1: got empty=%b want 0", empty0); end
        tick();
        checks++; if (data_out0 !== 2'b01 || valid_out0 !== 1'b1) begin errors++; $display("FAIL edge_late_pop: got %b/%b want 01/1", data_out0, valid_out0); end
        tick();
        pop0 = 1'b0;
        checks++; if (valid_out0 !== 1'b0 || empty0 !== 1'b1) begin errors++; $display("FAIL edge_drained: got v=%b e=%b want 0 1", valid_out0, empty0); end
    endtask

`ifdef DEMUX_DROP_CNT_EN
    // Five drops on lane 0 with a 2-bit counter saturate at 3
    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 2'(i));
        end
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 2'b11);
        end
        checks++; if (drop_cnt0 !== 2'd3 || drop_cnt1 !== 2'd0) begin errors++; $display("FAIL sat_drop_cnt: got %0d/%0d want 3/0", drop_cnt0, drop_cnt1); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", overflow); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset_L = 1'b0;
        test_reset();
        test_routing();
        test_full_wrap();
        test_full_push_pop();
        test_empty_edges();
`ifdef DEMUX_DROP_CNT_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
